// File: rtl/gsample_uart_framer_pkg.sv
// Shared types, constants and helpers for the accelerometer ASCII framer.
package gframe_pkg;

  localparam int unsigned AXIS_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned MSG_LEN = 17;
  localparam int unsigned IDX_W   = 5;

  localparam logic [BYTE_W-1:0] ASCII_LT  = 8'h3C;
  localparam logic [BYTE_W-1:0] ASCII_BAR = 8'h7C;
  localparam logic [BYTE_W-1:0] ASCII_GT  = 8'h3E;
  localparam logic [BYTE_W-1:0] ASCII_NL  = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  typedef struct packed {
    logic [AXIS_W-1:0] x;
    logic [AXIS_W-1:0] y;
    logic [AXIS_W-1:0] z;
  } sample_t;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [BYTE_W-1:0] nibble_to_hex(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + BYTE_W'(n);
    end
    return 8'h37 + BYTE_W'(n);
  endfunction

endpackage

// File: rtl/gsample_uart_framer_if.sv
// Sample input strobe and UART byte stream bundled for the framer.
interface gsample_uart_framer_if;

  logic                          in_valid;
  logic [gframe_pkg::AXIS_W-1:0] in_x;
  logic [gframe_pkg::AXIS_W-1:0] in_y;
  logic [gframe_pkg::AXIS_W-1:0] in_z;
  logic                          out_valid;
  logic                          out_ready;
  logic [gframe_pkg::BYTE_W-1:0] out_data;
  logic                          out_last;

  // Sample source and UART side.
  modport master (
    output in_valid, in_x, in_y, in_z, out_ready,
    input  out_valid, out_data, out_last
  );

  // Framer side.
  modport slave (
    input  in_valid, in_x, in_y, in_z, out_ready,
    output out_valid, out_data, out_last
  );

endinterface

// File: rtl/gsample_uart_framer_byte_mux.sv
// Selects the ASCII byte of the captured frame at the current index.
module framer_byte_mux
  import gframe_pkg::*;
(
  input  sample_t           i_frame,
  input  logic [IDX_W-1:0]  i_index,
  output logic [BYTE_W-1:0] o_data_c,
  output logic              o_last_c
);

  // Fixed frame layout "<xxxx|yyyy|zzzz>\n", digits MSB first.
  always_comb begin
    o_data_c = 8'h00;
    o_last_c = 1'b0;
    case (i_index)
      5'd0:  o_data_c = ASCII_LT;
      5'd1:  o_data_c = nibble_to_hex(i_frame.x[15:12]);
      5'd2:  o_data_c = nibble_to_hex(i_frame.x[11:8]);
      5'd3:  o_data_c = nibble_to_hex(i_frame.x[7:4]);
      5'd4:  o_data_c = nibble_to_hex(i_frame.x[3:0]);
      5'd5:  o_data_c = ASCII_BAR;
      5'd6:  o_data_c = nibble_to_hex(i_frame.y[15:12]);
      5'd7:  o_data_c = nibble_to_hex(i_frame.y[11:8]);
      5'd8:  o_data_c = nibble_to_hex(i_frame.y[7:4]);
      5'd9:  o_data_c = nibble_to_hex(i_frame.y[3:0]);
      5'd10: o_data_c = ASCII_BAR;
      5'd11: o_data_c = nibble_to_hex(i_frame.z[15:12]);
      5'd12: o_data_c = nibble_to_hex(i_frame.z[11:8]);
      5'd13: o_data_c = nibble_to_hex(i_frame.z[7:4]);
      5'd14: o_data_c = nibble_to_hex(i_frame.z[3:0]);
      5'd15: o_data_c = ASCII_GT;
      5'd16: begin
        o_data_c = ASCII_NL;
        o_last_c = 1'b1;
      end
      default: begin
        o_data_c = 8'h00;
        o_last_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/gsample_uart_framer.sv
// Decimates accelerometer samples, buffers one pending sample and streams
// each as a 17-byte ASCII frame with valid/ready backpressure.
module gsample_uart_framer
  import gframe_pkg::*;
#(
  parameter int unsigned DECIM   = 1,
  parameter int unsigned DROP_W  = 8,
  parameter int unsigned FRAME_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  gsample_uart_framer_if.slave    io_bus,
  output logic                    busy,
  output logic [FRAME_W-1:0]      frame_cnt,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int unsigned DEC_W = 8;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [DEC_W-1:0]   r_decim;
  sample_t            r_pend;
  logic               r_full;
  sample_t            r_frame;
  logic [IDX_W-1:0]   r_index;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [DROP_W-1:0]  r_drop_cnt;

  logic               w_accept;
  logic               w_fwd;
  logic               w_load;
  logic               w_out_valid;
  logic               w_advance;
  logic               w_done;
  logic [BYTE_W-1:0]  w_mux_data;
  logic               w_mux_last;
  sample_t            w_sample;

  assign w_accept = io_bus.in_valid && enable;
  assign w_fwd    = w_accept && (r_decim == DEC_LAST);
  assign w_sample = '{x: io_bus.in_x, y: io_bus.in_y, z: io_bus.in_z};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_out_valid  = 1'b0;
    w_advance    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_full && enable) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_load       = 1'b1;
        w_state_next = SEND;
      end
      SEND: begin
        w_out_valid = 1'b1;
        if (io_bus.out_ready) begin
          if (r_index == IDX_LAST) begin
            w_done       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Decimation counter advances only on accepted strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_decim <= '0;
    end else if (w_accept) begin
      r_decim <= (r_decim == DEC_LAST) ? '0 : r_decim + DEC_W'(1);
    end
  end

  // Pending buffer: a forwarded sample wins over a same-cycle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_full     <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_fwd) begin
      r_pend <= w_sample;
      r_full <= 1'b1;
      if (r_full && !w_load && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end else if (w_load) begin
      r_full <= 1'b0;
    end
  end

  // Frame capture, byte index and completed-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame     <= '0;
      r_index     <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_load) begin
        r_frame <= r_pend;
        r_index <= '0;
      end else if (w_advance) begin
        r_index <= r_index + IDX_W'(1);
      end
      if (w_done) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
    end
  end

  framer_byte_mux u_byte_mux (
    .i_frame  (r_frame),
    .i_index  (r_index),
    .o_data_c (w_mux_data),
    .o_last_c (w_mux_last)
  );

  assign io_bus.out_valid = w_out_valid;
  assign io_bus.out_data  = w_out_valid ? w_mux_data : 8'h00;
  assign io_bus.out_last  = w_out_valid && w_mux_last;
  assign busy             = (r_state != IDLE);
  assign frame_cnt        = r_frame_cnt;
  assign drop_cnt         = r_drop_cnt;

endmodule

// File: tb/tb_gsample_uart_framer.sv
// Directed bench for the accelerometer ASCII framer.
module tb_gsample_uart_framer;

  typedef logic [7:0] frame_t [17];

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en1;
  logic        busy0, busy1;
  logic [15:0] fc0, fc1;
  logic [7:0]  dc0, dc1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         l0[$];
  bit         l1[$];
  bit         stall0 = 1'b0;
  logic [8:0] held0  = '0;

  localparam frame_t T1 = '{8'h3C, 8'h31, 8'h41, 8'h32, 8'h46, 8'h7C,
                            8'h30, 8'h30, 8'h30, 8'h30, 8'h7C,
                            8'h46, 8'h46, 8'h46, 8'h46, 8'h3E, 8'h0A};

  gsample_uart_framer_if bus0 ();
  gsample_uart_framer_if bus1 ();

  gsample_uart_framer #(.DECIM(1), .DROP_W(8), .FRAME_W(16)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .enable    (en0),
    .io_bus    (bus0),
    .busy      (busy0),
    .frame_cnt (fc0),
    .drop_cnt  (dc0)
  );

  gsample_uart_framer #(.DECIM(4), .DROP_W(8), .FRAME_W(16)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .enable    (en1),
    .io_bus    (bus1),
    .busy      (busy1),
    .frame_cnt (fc1),
    .drop_cnt  (dc1)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte capture and stall-stability watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        check_eq("stall_hold", {bus0.out_valid, bus0.out_last, bus0.out_data}, {1'b1, held0});
      end
      stall0 = bus0.out_valid && !bus0.out_ready;
      held0  = {bus0.out_last, bus0.out_data};
      if (bus0.out_valid && bus0.out_ready) begin
        q0.push_back(bus0.out_data);
        l0.push_back(bus0.out_last);
      end
      if (bus1.out_valid && bus1.out_ready) begin
        q1.push_back(bus1.out_data);
        l1.push_back(bus1.out_last);
      end
    end
  end

  function automatic frame_t mk_frame(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    frame_t f;
    string  hx = "0123456789ABCDEF";
    f[0]  = 8'h3C;
    f[5]  = 8'h7C;
    f[10] = 8'h7C;
    f[15] = 8'h3E;
    f[16] = 8'h0A;
    for (int i = 0; i < 4; i++) begin
      f[1 + i]  = hx[int'(x[15 - 4*i -: 4])];
      f[6 + i]  = hx[int'(y[15 - 4*i -: 4])];
      f[11 + i] = hx[int'(z[15 - 4*i -: 4])];
    end
    return f;
  endfunction

  task automatic cmp_frame(input logic [7:0] q[$], input bit l[$], input int base,
                           input frame_t e, input string tag);
    for (int i = 0; i < 17; i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), (base + i < q.size()) ? q[base + i] : 8'hXX, e[i]);
      check_eq($sformatf("%s_last%0d", tag, i), (base + i < l.size()) ? l[base + i] : 1'bx,
               (i == 16) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic strobe0(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(posedge clk); #1;
    bus0.in_valid = 1'b1;
    bus0.in_x = x;
    bus0.in_y = y;
    bus0.in_z = z;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
  endtask

  task automatic strobe1(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(posedge clk); #1;
    bus1.in_valid = 1'b1;
    bus1.in_x = x;
    bus1.in_y = y;
    bus1.in_z = z;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_q0(input int n, input int budget, input bit toggle, input string tag);
    int c = 0;
    while (q0.size() < n && c < budget) begin
      @(posedge clk); #1;
      if (toggle) bus0.out_ready = ~bus0.out_ready;
      c++;
    end
    if (q0.size() < n) check_eq({tag, "_timeout"}, q0.size(), n);
  endtask

  task automatic clear0();
    q0.delete();
    l0.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en0 = 1'b1;
    en1 = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_x = '0; bus0.in_y = '0; bus0.in_z = '0;
    bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_x = '0; bus1.in_y = '0; bus1.in_z = '0;
    bus1.out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    check_eq("rst_valid", bus0.out_valid, 1'b0);
    check_eq("rst_data",  bus0.out_data, 8'h00);
    check_eq("rst_last",  bus0.out_last, 1'b0);
    check_eq("rst_busy",  busy0, 1'b0);
    check_eq("rst_fcnt",  fc0, 16'd0);
    check_eq("rst_dcnt",  dc0, 8'd0);

    // Single frame, free-running UART, plus first-byte latency
    clear0();
    strobe0(16'h1A2F, 16'h0000, 16'hFFFF);
    idle(1);
    check_eq("lat_load_valid", bus0.out_valid, 1'b0);
    check_eq("lat_load_busy",  busy0, 1'b1);
    idle(1);
    check_eq("lat_first_valid", bus0.out_valid, 1'b1);
    check_eq("lat_first_data",  bus0.out_data, 8'h3C);
    wait_q0(17, 100, 1'b0, "t1");
    cmp_frame(q0, l0, 0, T1, "t1");
    idle(3);
    check_eq("t1_fcnt", fc0, 16'd1);
    check_eq("t1_busy", busy0, 1'b0);
    check_eq("t1_count", q0.size(), 17);

    // Same frame with ready toggling every cycle
    clear0();
    strobe0(16'h1A2F, 16'h0000, 16'hFFFF);
    wait_q0(17, 200, 1'b1, "t2");
    bus0.out_ready = 1'b1;
    cmp_frame(q0, l0, 0, T1, "t2");
    idle(3);
    check_eq("t2_fcnt", fc0, 16'd2);
    check_eq("t2_count", q0.size(), 17);

    // Decimation by 4 on the second instance
    for (int v = 0; v < 8; v++) begin
      strobe1(16'(v), 16'h0000, 16'h0000);
      idle(40);
    end
    check_eq("t3_count", q1.size(), 34);
    check_eq("t3_x0_lsd", q1[4], 8'h33);
    check_eq("t3_x1_lsd", q1[21], 8'h37);
    cmp_frame(q1, l1, 0,  mk_frame(16'h0003, 16'h0000, 16'h0000), "t3a");
    cmp_frame(q1, l1, 17, mk_frame(16'h0007, 16'h0000, 16'h0000), "t3b");
    check_eq("t3_fcnt", fc1, 16'd2);
    check_eq("t3_dcnt", dc1, 8'd0);

    // Overrun while the UART stalls frame A
    clear0();
    bus0.out_ready = 1'b0;
    strobe0(16'h1111, 16'h2222, 16'h3333);
    idle(5);
    check_eq("t4_stall_valid", bus0.out_valid, 1'b1);
    check_eq("t4_stall_data",  bus0.out_data, 8'h3C);
    strobe0(16'hAAAA, 16'hBBBB, 16'hCCCC);
    strobe0(16'h5555, 16'h6666, 16'h7777);
    strobe0(16'hDDDD, 16'h0123, 16'hBEEF);
    check_eq("t4_dcnt", dc0, 8'd2);
    bus0.out_ready = 1'b1;
    wait_q0(34, 200, 1'b0, "t4");
    cmp_frame(q0, l0, 0,  mk_frame(16'h1111, 16'h2222, 16'h3333), "t4a");
    cmp_frame(q0, l0, 17, mk_frame(16'hDDDD, 16'h0123, 16'hBEEF), "t4d");
    idle(3);
    check_eq("t4_fcnt", fc0, 16'd4);
    check_eq("t4_dcnt_hold", dc0, 8'd2);
    check_eq("t4_count", q0.size(), 34);

    // enable falls mid-frame: frame completes, then framing is blocked
    clear0();
    strobe0(16'h0F0F, 16'h8421, 16'h7E57);
    wait_q0(5, 100, 1'b0, "t5a");
    en0 = 1'b0;
    wait_q0(17, 100, 1'b0, "t5b");
    idle(3);
    cmp_frame(q0, l0, 0, mk_frame(16'h0F0F, 16'h8421, 16'h7E57), "t5");
    check_eq("t5_fcnt", fc0, 16'd5);
    check_eq("t5_busy", busy0, 1'b0);
    strobe0(16'h9999, 16'h9999, 16'h9999);
    idle(30);
    check_eq("t5_blocked_count", q0.size(), 17);
    check_eq("t5_blocked_fcnt", fc0, 16'd5);
    check_eq("t5_blocked_dcnt", dc0, 8'd2);
    check_eq("t5_blocked_busy", busy0, 1'b0);
    en0 = 1'b1;
    clear0();
    strobe0(16'hCAFE, 16'hF00D, 16'h0001);
    wait_q0(17, 100, 1'b0, "t5c");
    cmp_frame(q0, l0, 0, mk_frame(16'hCAFE, 16'hF00D, 16'h0001), "t5r");
    idle(3);
    check_eq("t5_resume_fcnt", fc0, 16'd6);

    // Reset at byte index 8 aborts the frame
    clear0();
    strobe0(16'h1234, 16'h5678, 16'h9ABC);
    wait_q0(8, 100, 1'b0, "t6a");
    rst = 1'b1;
    idle(1);
    check_eq("t6_valid", bus0.out_valid, 1'b0);
    check_eq("t6_fcnt",  fc0, 16'd0);
    check_eq("t6_dcnt",  dc0, 8'd0);
    check_eq("t6_busy",  busy0, 1'b0);
    rst = 1'b0;
    clear0();
    idle(10);
    check_eq("t6_quiet", q0.size(), 0);
    strobe0(16'h0000, 16'hFFFF, 16'h8000);
    wait_q0(17, 100, 1'b0, "t6b");
    check_eq("t6_first", q0[0], 8'h3C);
    cmp_frame(q0, l0, 0, mk_frame(16'h0000, 16'hFFFF, 16'h8000), "t6");
    idle(3);
    check_eq("t6_fcnt_after", fc0, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gsample_uart_framer.md
Name: gsample_uart_framer

Overview:
- Sequences accelerometer samples (x/y/z, 16 bit each) into fixed ASCII frames "<xxxx|yyyy|zzzz>\n" and emits them byte-by-byte over a valid/ready stream into the UART transmitter.
- Replaces strobe-paced byte indexing with true backpressure, sample decimation, a one-deep pending buffer and overrun accounting.
- Sits between the gsensor sample output and uart_tx.

Parameters:
- DECIM, 1, forward every DECIM-th accepted sample; valid range 1..255.
- DROP_W, 8, width of the saturating drop counter.
- FRAME_W, 16, width of the wrapping frame counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  level; when low, no new frames start
- in_valid  in  1  one-cycle sample strobe; no backpressure
- in_x  in  16  sample X, two's complement (raw bits printed)
- in_y  in  16  sample Y
- in_z  in  16  sample Z
- out_valid  out  1  byte valid to UART
- out_ready  in  1  UART accepts byte
- out_data  out  8  ASCII byte
- out_last  out  1  high with the '\n' byte
- busy  out  1  frame in progress (state != IDLE)
- frame_cnt  out  FRAME_W  frames fully sent, wraps
- drop_cnt  out  DROP_W  samples overwritten in pending buffer, saturates at all-ones

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_last=0, busy=0, frame_cnt=0, drop_cnt=0
  - decimation counter=0, pending empty, state IDLE
  - rst mid-frame aborts the frame at once; no further bytes are emitted.
- Decimation:
  - Counter increments on each in_valid while enable=1.
  - When the counter equals DECIM-1, the sample is forwarded to pending and the counter returns to 0.
  - in_valid while enable=0 is ignored and does not advance the counter.
- Pending buffer (1 entry, 48 bits + full flag):
  - A forwarded sample while pending is empty sets full.
  - A forwarded sample while pending is full overwrites the payload and increments drop_cnt.
  - If the FSM empties pending in the same cycle a forwarded sample arrives, the new sample lands and full stays 1 with no drop.
- FSM:
  - IDLE: if pending full and enable=1, go to LOAD.
  - LOAD (1 cycle):
    - copy pending into the frame register and clear pending full;
    - byte index=0; go to SEND.
  - SEND:
    - out_valid=1; out_data=frame byte[index].
    - On out_valid&&out_ready with index<16: index++.
    - On out_valid&&out_ready with index==16: frame_cnt++ and go to IDLE.
  - out_data and out_last are stable while out_valid=1 and out_ready=0. out_valid is never dropped without a handshake.
  - enable falling during SEND does not abort the frame; only the next frame start is blocked.
- Frame byte order (index 0..16):
  - 0: '<' (0x3C)
  - 1–4: x hex digits MSB first
  - 5: '|' (0x7C)
  - 6–9: y hex digits
  - 10: '|'
  - 11–14: z hex digits
  - 15: '>' (0x3E)
  - 16: '\n' (0x0A)
- Hex digits are uppercase: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46.
- Latency:
  - in_valid forwarded to pending: pending full next cycle.
  - pending full to IDLE→LOAD: 1 cycle.
  - LOAD→SEND: 1 cycle, so first out_valid is 3 cycles after the forwarded in_valid.
  - Back-to-back frames with out_ready held high: 17 byte cycles plus 2 (IDLE, LOAD) per frame.
- Captured frame data is immune to later samples; only pending is overwritten.
- frame_cnt wraps all-ones→0. drop_cnt holds at all-ones.

Decomposition:
- Package gframe_pkg:
  - MSG_LEN=17
  - ASCII constants for '<', '|', '>', '\n'
  - state enum {IDLE, LOAD, SEND}
  - function nibble_to_hex(4b)→8b
- Sub-module: framer_byte_mux, combinational frame register + index → out_data/out_last.
- The top-level holds the FSM, decimation counter, pending buffer and counters.

Test Plan:
- Reset then one in_valid with x=16'h1A2F, y=16'h0000, z=16'hFFFF, out_ready=1:
  - emits 3C 31 41 32 46 7C 30 30 30 30 7C 46 46 46 46 3E 0A;
  - out_last only on 0A; frame_cnt=1.
- Same sample, out_ready toggled 1/0 every cycle:
  - identical byte sequence; out_data is stable during stalls; no byte is duplicated or skipped.
- DECIM=4, 8 strobes with x=0..7 and y=z=0, out_ready=1, strobes spaced 40 cycles:
  - exactly 2 frames, x fields "0003" and "0007".
- out_ready=0 during frame A, then 3 more forwarded samples B, C, D, then out_ready=1:
  - drop_cnt=2; frames A then D are sent; frame_cnt=2.
- enable=0 mid-frame:
  - current frame completes; busy falls; a subsequent strobe yields no frame and no counter change.
  - enable=1 resumes framing.
- rst asserted at byte index 8:
  - next cycle out_valid=0, frame_cnt and drop_cnt are 0, busy=0.
  - After release a new sample produces a full frame starting with 3C.
